// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT twiddle-coefficient sequencer.
package fft_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // Ceiling log2 usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Butterflies (and therefore twiddle transfers) in one N-point radix-2 transform.
  function automatic int xfer_count(input int n);
    return clog2(n) * (n / 2);
  endfunction

endpackage

// File: rtl/fft_coeff_sched_if.sv
// Twiddle-index handshake between the sequencer (master) and the ROM/butterfly consumer (slave).
interface fft_coeff_sched_if
  import fft_pkg::*;
#(
  parameter int N = 8
);
  localparam int LOGN = clog2(N);
  localparam int IDXW = LOGN - 1;

  logic            tw_valid;
  logic            tw_ready;
  logic [IDXW-1:0] tw_idx;
  logic [LOGN-1:0] stage;
  logic [LOGN-2:0] bfly;
  logic            last_bfly;

  modport master (
    output tw_valid,
    output tw_idx,
    output stage,
    output bfly,
    output last_bfly,
    input  tw_ready
  );

  modport slave (
    input  tw_valid,
    input  tw_idx,
    input  stage,
    input  bfly,
    input  last_bfly,
    output tw_ready
  );
endinterface

// File: rtl/fft_coeff_addr_gen.sv
// DIT twiddle index: keep the low 'stage' bits of the butterfly number and
// left-align them into the 0..N/2-1 index range.
module fft_coeff_addr_gen #(
  parameter int LOGN = 3
) (
  input  logic [LOGN-1:0] stage,
  input  logic [LOGN-2:0] bfly,
  output logic [LOGN-2:0] tw_idx
);
  localparam int IDXW = LOGN - 1;

  logic [IDXW-1:0] masked_s;
  logic [LOGN-1:0] shamt_s;

  // Mask bfly to (bfly mod 2^stage), then shift by LOGN-1-stage.
  always_comb begin
    masked_s = '0;
    for (int i = 0; i < IDXW; i++) begin
      if (i < int'(stage)) begin
        masked_s[i] = bfly[i];
      end else begin
        masked_s[i] = 1'b0;
      end
    end
    shamt_s = LOGN'(IDXW) - stage;
    tw_idx  = masked_s << shamt_s;
  end
endmodule

// File: rtl/fft_coeff_sched.sv
// Twiddle-coefficient sequencer for the radix-2 DIT FFT: walks every stage and
// butterfly after start, one index per accepted transfer, then pulses done.
// Optional build macro FFT_COEFF_SCHED_STALL_CNT_EN adds the stall_cnt output
// (cycles with tw_valid & !tw_ready in the current transform, saturating).
module fft_coeff_sched
  import fft_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  fft_coeff_sched_if.master tw,
  output logic              busy,
  output logic              done
`ifdef FFT_COEFF_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int LOGN = clog2(N);
  localparam int IDXW = LOGN - 1;
  localparam int BW   = LOGN - 1;
  localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);
  localparam logic [BW-1:0]   LAST_BFLY  = BW'(N / 2 - 1);

  sched_state_e    state_r, state_nxt_s;
  logic [LOGN-1:0] stage_r, stage_nxt_s;
  logic [BW-1:0]   bfly_r, bfly_nxt_s;
  logic [IDXW-1:0] idx_r, idx_nxt_s;
  logic            valid_r, last_r, busy_r, done_r;
  logic            last_nxt_s;
  logic            xfer_s;

  assign xfer_s = valid_r & tw.tw_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and next stage/butterfly counters; abort overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    stage_nxt_s = stage_r;
    bfly_nxt_s  = bfly_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
      stage_nxt_s = '0;
      bfly_nxt_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s = ST_RUN;
            stage_nxt_s = '0;
            bfly_nxt_s  = '0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (xfer_s) begin
            if ((stage_r == LAST_STAGE) && (bfly_r == LAST_BFLY)) begin
              state_nxt_s = ST_DONE;
              stage_nxt_s = '0;
              bfly_nxt_s  = '0;
            end else if (bfly_r == LAST_BFLY) begin
              stage_nxt_s = stage_r + LOGN'(1);
              bfly_nxt_s  = '0;
            end else begin
              bfly_nxt_s  = bfly_r + BW'(1);
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_IDLE;
          stage_nxt_s = '0;
          bfly_nxt_s  = '0;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          stage_nxt_s = '0;
          bfly_nxt_s  = '0;
        end
      endcase
    end
    last_nxt_s = (state_nxt_s == ST_RUN) && (bfly_nxt_s == LAST_BFLY);
  end

  // Index for the item that will be presented next cycle, so tw_idx is registered.
  fft_coeff_addr_gen #(
    .LOGN(LOGN)
  ) u_addr_gen (
    .stage (stage_nxt_s),
    .bfly  (bfly_nxt_s),
    .tw_idx(idx_nxt_s)
  );

  // Registered outputs; counters only move on transfer, so a stall holds them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      stage_r <= '0;
      bfly_r  <= '0;
      idx_r   <= '0;
      last_r  <= 1'b0;
    end else begin
      valid_r <= (state_nxt_s == ST_RUN);
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
      stage_r <= stage_nxt_s;
      bfly_r  <= bfly_nxt_s;
      idx_r   <= idx_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  assign tw.tw_valid  = valid_r;
  assign tw.tw_idx    = idx_r;
  assign tw.stage     = stage_r;
  assign tw.bfly      = bfly_r;
  assign tw.last_bfly = last_r;
  assign busy         = busy_r;
  assign done         = done_r;

`ifdef FFT_COEFF_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Stall counter: cleared when a transform starts, saturates, held through done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_RUN)) begin
      stall_cnt_r <= 16'h0000;
    end else if (valid_r && !tw.tw_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  // Stall instrumentation is not built in this configuration.
`endif

endmodule

// File: tb/tb_fft_coeff_sched.sv
// Self-checking bench for fft_coeff_sched (N=8) using a scoreboard of expected
// twiddle items. Build with FFT_COEFF_SCHED_STALL_CNT_EN to cover stall_cnt.
module tb_fft_coeff_sched;

  typedef struct {
    logic [1:0] idx;
    logic [2:0] stage;
    logic [1:0] bfly;
    logic       last;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic busy;
  logic done;
`ifdef FFT_COEFF_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fft_coeff_sched_if #(.N(8)) tw_if ();

  fft_coeff_sched #(.N(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .abort(abort),
    .tw   (tw_if),
    .busy (busy),
    .done (done)
`ifdef FFT_COEFF_SCHED_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [1:0] idx_tab [12] = '{2'd0, 2'd0, 2'd0, 2'd0,
                               2'd0, 2'd2, 2'd0, 2'd2,
                               2'd0, 2'd1, 2'd2, 2'd3};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor: sample away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (tw_if.tw_valid && tw_if.tw_ready && !abort) begin
      if (sb_q.size() == 0) begin
        chk_eq("unexpected_xfer", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        chk_eq("xfer_idx",   tw_if.tw_idx,    mon_e.idx);
        chk_eq("xfer_stage", tw_if.stage,     mon_e.stage);
        chk_eq("xfer_bfly",  tw_if.bfly,      mon_e.bfly);
        chk_eq("xfer_last",  tw_if.last_bfly, mon_e.last);
        xfer_cnt++;
        if (sb_q.size() == 0) last_cyc = cyc;
      end
    end else if (tw_if.tw_valid && !tw_if.tw_ready && !abort && sb_q.size() > 0) begin
      chk_eq("hold_idx",   tw_if.tw_idx, sb_q[0].idx);
      chk_eq("hold_stage", tw_if.stage,  sb_q[0].stage);
      chk_eq("hold_bfly",  tw_if.bfly,   sb_q[0].bfly);
    end
    if (done) done_cnt++;
  end

  task automatic push_transform();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      e.stage = 3'(i / 4);
      e.bfly  = 2'(i % 4);
      e.idx   = idx_tab[i];
      e.last  = ((i % 4) == 3);
      sb_q.push_back(e);
    end
  endtask

  task automatic do_start(input string tag);
    sb_q.delete();
    push_transform();
    xfer_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_eq({tag, "_lat_valid"}, tw_if.tw_valid, 1);
    chk_eq({tag, "_lat_busy"},  busy, 1);
    chk_eq({tag, "_lat_stage"}, tw_if.stage, 0);
    chk_eq({tag, "_lat_bfly"},  tw_if.bfly, 0);
`ifdef FFT_COEFF_SCHED_STALL_CNT_EN
    chk_eq({tag, "_stall_clr"}, stall_cnt, 0);
`endif
  endtask

  task automatic wait_item(input string tag, input int s, input int b);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tw_if.tw_valid && tw_if.stage == 3'(s) && tw_if.bfly == 2'(b)) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk_eq({tag, "_item_seen"}, found, 1);
  endtask

  task automatic wait_done(input string tag, input int exp_stall, input bit poke_start);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk_eq({tag, "_done_seen"},  seen, 1);
    chk_eq({tag, "_done_lat"},   cyc, last_cyc);
    chk_eq({tag, "_xfers"},      xfer_cnt, 12);
    chk_eq({tag, "_sb_empty"},   sb_q.size(), 0);
    chk_eq({tag, "_done_valid"}, tw_if.tw_valid, 0);
    chk_eq({tag, "_done_busy"},  busy, 0);
`ifdef FFT_COEFF_SCHED_STALL_CNT_EN
    chk_eq({tag, "_stall_done"}, stall_cnt, 16'(exp_stall));
`endif
    if (poke_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_eq({tag, "_done_pulse"}, done, 0);
    chk_eq({tag, "_idle_valid"}, tw_if.tw_valid, 0);
`ifdef FFT_COEFF_SCHED_STALL_CNT_EN
    chk_eq({tag, "_stall_hold"}, stall_cnt, 16'(exp_stall));
`endif
    if (poke_start) begin
      @(posedge clk); #1;
      chk_eq({tag, "_start_in_done"}, tw_if.tw_valid, 0);
      chk_eq({tag, "_start_in_done_busy"}, busy, 0);
    end
    if (exp_stall < 0) chk_eq({tag, "_bad_arg"}, exp_stall, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk_eq({tag, "_valid"}, tw_if.tw_valid, 0);
    chk_eq({tag, "_busy"},  busy, 0);
    chk_eq({tag, "_done"},  done, 0);
    chk_eq({tag, "_idx"},   tw_if.tw_idx, 0);
    chk_eq({tag, "_stage"}, tw_if.stage, 0);
    chk_eq({tag, "_bfly"},  tw_if.bfly, 0);
    chk_eq({tag, "_last"},  tw_if.last_bfly, 0);
`ifdef FFT_COEFF_SCHED_STALL_CNT_EN
    chk_eq({tag, "_stall"}, stall_cnt, 0);
`endif
  endtask

  initial begin
    int d0;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tw_if.tw_ready = 1'b1;
    #2;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: full transform, consumer always ready.
    do_start("t1");
    wait_done("t1", 0, 1'b0);

    // 2: stalls of 2 cycles at (0,2) and 3 cycles at (1,1).
    do_start("t2");
    wait_item("t2a", 0, 2);
    tw_if.tw_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk_eq("t2_hold_a", tw_if.tw_idx, 0);
    tw_if.tw_ready = 1'b1;
    wait_item("t2b", 1, 1);
    tw_if.tw_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk_eq("t2_hold_b_idx",  tw_if.tw_idx, 2);
    chk_eq("t2_hold_b_bfly", tw_if.bfly, 1);
    tw_if.tw_ready = 1'b1;
    wait_done("t2", 5, 1'b0);

    // 3: abort at stage 2 butterfly 1.
    do_start("t3");
    wait_item("t3", 2, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_zero("t3_abort");
    sb_q.delete();
    d0 = done_cnt;
    repeat (20) begin @(posedge clk); #1; end
    chk_eq("t3_no_done", done_cnt, d0);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk_eq("t3_abort_wins", tw_if.tw_valid, 0);

    // 4: start pulsed mid-run and during DONE is ignored.
    do_start("t4");
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t4", 0, 1'b1);

    // 5: asynchronous reset mid-run, then a clean restart.
    do_start("t5");
    repeat (4) begin @(posedge clk); #1; end
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    chk_zero("t5_rst");
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("t5_no_done", done_cnt, d0);
    do_start("t5r");
    wait_done("t5r", 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
